pc_fetch: RTL and testbench

PC_FETCH -- requirements
Module: pc_fetch

---
 rtl/pc_fetch_pkg.sv | 10 +
 rtl/pc_fetch_sync_fifo.sv | 40 ++++
 rtl/pc_fetch.sv | 61 ++++++
 tb/tb_pc_fetch.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_fetch_pkg.sv
// pc_fetch_pkg: shared fetch-unit widths, reset address and control-level encodings
package pc_fetch_pkg;
  localparam int INST_WIDTH = 32;
  localparam int INST_ADDR_WIDTH = 32;
  localparam logic [31:0] INI_INST_ADDR = 32'h0;
  localparam logic RST = 1'b0;
  localparam logic UNRST = 1'b1;
  localparam logic HOLD = 1'b1;
  localparam logic JUMP = 1'b1;
endpackage

// File: rtl/pc_fetch_sync_fifo.sv
// pc_fetch_sync_fifo: parametrised FIFO (clk, rst, push/din, pop/dout, flush, count) used as address queue and fetch buffer
module pc_fetch_sync_fifo import pc_fetch_pkg::*; #(
  parameter int W = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           dout,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] rd, wr;
  logic wr_en, rd_en;
  always_comb begin
    rd_en = pop && count != '0 && !flush;
    wr_en = push && !flush && (count != (AW+1)'(DEPTH) || rd_en);
    dout = mem[rd];
  end
  always_ff @(posedge clk or negedge rst)
    if (rst == RST) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else if (flush) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else begin
      rd <= rd + AW'(rd_en);
      wr <= wr + AW'(wr_en);
      count <= count + (AW+1)'(wr_en) - (AW+1)'(rd_en);
    end
  always_ff @(posedge clk)
    if (wr_en) mem[wr] <= din;
endmodule

// File: rtl/pc_fetch.sv
// pc_fetch: credit-based instruction fetch (clk, rst, jump/jump_addr, hold, req_*, rsp_*, inst_valid/inst_o/pc_o/inst_ready)
module pc_fetch import pc_fetch_pkg::*; #(
  parameter int ADDR_W = INST_ADDR_WIDTH,
  parameter int INST_W = INST_WIDTH,
  parameter int DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(INI_INST_ADDR),
  parameter int PC_STEP = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_addr,
  input  logic              hold,
  output logic              req_valid,
  output logic [ADDR_W-1:0] req_addr,
  input  logic              req_ready,
  input  logic              rsp_valid,
  input  logic [INST_W-1:0] rsp_inst,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst_o,
  output logic [ADDR_W-1:0] pc_o,
  input  logic              inst_ready
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic [ADDR_W-1:0] fetch_pc, aq_head;
  logic [ADDR_W+INST_W-1:0] fb_head;
  logic [CW-1:0] aq_cnt, fb_cnt, disc;
  logic [CW+1:0] used;
  logic jmp, req_ok, fire, rsp_hit, drop, accept, pop;
  always_comb begin
    jmp = jump == JUMP;
    used = (CW+2)'(fb_cnt) + (CW+2)'(aq_cnt) + (CW+2)'(disc);
    req_ok = hold != HOLD && !jmp && used < (CW+2)'(DEPTH);
    req_valid = req_ok && rst == UNRST;
    req_addr = fetch_pc;
    fire = req_ok && req_ready;
    rsp_hit = rsp_valid && (disc != '0 || aq_cnt != '0);
    drop = rsp_valid && disc != '0;
    accept = rsp_hit && disc == '0 && !jmp;
    inst_valid = fb_cnt != '0;
    pop = inst_valid && inst_ready && !jmp;
    pc_o = rst == UNRST ? fb_head[ADDR_W+INST_W-1:INST_W] : '0;
    inst_o = rst == UNRST ? fb_head[INST_W-1:0] : '0;
  end
  always_ff @(posedge clk or negedge rst)
    if (rst == RST) begin
      fetch_pc <= RESET_ADDR;
      disc <= '0;
    end else begin
      fetch_pc <= jmp ? jump_addr : fire ? fetch_pc + ADDR_W'(PC_STEP) : fetch_pc;
      disc <= jmp ? disc + aq_cnt - CW'(rsp_hit) : disc - CW'(drop);
    end
  pc_fetch_sync_fifo #(.W(ADDR_W), .DEPTH(DEPTH)) u_aq (
    .clk(clk), .rst(rst), .push(fire), .pop(accept), .flush(jmp),
    .din(fetch_pc), .dout(aq_head), .count(aq_cnt)
  );
  pc_fetch_sync_fifo #(.W(ADDR_W+INST_W), .DEPTH(DEPTH)) u_fb (
    .clk(clk), .rst(rst), .push(accept), .pop(pop), .flush(jmp),
    .din({aq_head, rsp_inst}), .dout(fb_head), .count(fb_cnt)
  );
endmodule

// File: tb/tb_pc_fetch.sv
// tb_pc_fetch: randomized and directed bench for pc_fetch against an epoch-tagged memory/stream model
module tb_pc_fetch;
  localparam int DEPTH = 4;
  logic clk = 0;
  logic rst = 0;
  logic jump = 0, hold = 0, req_ready = 1, rsp_valid = 0, inst_ready = 1;
  logic [31:0] jump_addr = 0, rsp_inst = 0;
  logic req_valid, inst_valid;
  logic [31:0] req_addr, inst_o, pc_o;
  logic w_rv, w_iv;
  logic [7:0] w_ra, w_pc;
  logic [31:0] w_inst;
  int checks = 0, errors = 0;
  typedef struct {logic [31:0] addr; int epoch; int due;} req_t;
  typedef struct {logic [31:0] pc; logic [31:0] inst;} ent_t;
  req_t mq[$];
  ent_t bq[$];
  logic [31:0] del_q[$], fq[$];
  logic [31:0] exp_fetch = 0;
  int epoch = 0, cyc = 0, last_due = 0, lat = 1;
  bit rand_lat = 0, force_rsp = 0;
  logic s_rv, s_iv;
  logic [31:0] s_ra, s_pc, s_inst;

  always #5 clk = ~clk;

  pc_fetch #(.ADDR_W(32), .INST_W(32), .DEPTH(DEPTH), .RESET_ADDR(32'h0), .PC_STEP(4)) dut (
    .clk(clk), .rst(rst), .jump(jump), .jump_addr(jump_addr), .hold(hold),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_inst(rsp_inst),
    .inst_valid(inst_valid), .inst_o(inst_o), .pc_o(pc_o), .inst_ready(inst_ready)
  );

  pc_fetch #(.ADDR_W(8), .INST_W(32), .DEPTH(DEPTH), .RESET_ADDR(8'hFC), .PC_STEP(4)) u_w8 (
    .clk(clk), .rst(rst), .jump(1'b0), .jump_addr(8'h00), .hold(1'b0),
    .req_valid(w_rv), .req_addr(w_ra), .req_ready(1'b1),
    .rsp_valid(1'b0), .rsp_inst(32'h0),
    .inst_valid(w_iv), .inst_o(w_inst), .pc_o(w_pc), .inst_ready(1'b1)
  );

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'hC0DE0000;
  endfunction

  task automatic do_reset();
    rst = 0; hold = 0; jump = 0; jump_addr = 0; req_ready = 1; inst_ready = 1;
    rsp_valid = 0; force_rsp = 0; rand_lat = 0; lat = 1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1;
    bq.delete(); mq.delete(); del_q.delete(); fq.delete();
    exp_fetch = 0; epoch = 0; last_due = 0;
  endtask

  // One clock: memory drives its response, outputs are compared with the model at
  // the falling edge, then the model applies what the coming rising edge does.
  task automatic cycle();
    req_t e;
    bit rsp_now, keep, exp_rv;
    int due;
    rsp_now = force_rsp || (mq.size() > 0 && mq[0].due <= cyc);
    rsp_valid = rsp_now;
    rsp_inst = (mq.size() > 0) ? mem_word(mq[0].addr) : $urandom;
    @(negedge clk);
    s_rv = req_valid; s_ra = req_addr; s_iv = inst_valid; s_pc = pc_o; s_inst = inst_o;
    exp_rv = !hold && !jump && (mq.size() + bq.size() < DEPTH);
    checks++;
    if (s_rv !== exp_rv) begin
      errors++;
      $display("FAIL req_valid cyc=%0d got %b exp %b", cyc, s_rv, exp_rv);
    end
    if (exp_rv && s_rv) begin
      checks++;
      if (s_ra !== exp_fetch) begin
        errors++;
        $display("FAIL req_addr cyc=%0d got %h exp %h", cyc, s_ra, exp_fetch);
      end
    end
    checks++;
    if (s_iv !== (bq.size() > 0)) begin
      errors++;
      $display("FAIL inst_valid cyc=%0d got %b exp %b", cyc, s_iv, bq.size() > 0);
    end
    if (bq.size() > 0) begin
      checks++;
      if (s_pc !== bq[0].pc || s_inst !== bq[0].inst) begin
        errors++;
        $display("FAIL head cyc=%0d got pc %h inst %h exp pc %h inst %h", cyc, s_pc, s_inst, bq[0].pc, bq[0].inst);
      end
    end
    keep = 0;
    if (rsp_now && mq.size() > 0) begin
      e = mq.pop_front();
      keep = (e.epoch == epoch) && !jump;
    end
    if (jump) begin
      epoch++;
      bq.delete();
      exp_fetch = jump_addr;
    end else begin
      if (s_iv && inst_ready) del_q.push_back(s_pc);
      if (inst_ready && bq.size() > 0) bq.delete(0);
      if (keep) bq.push_back('{e.addr, mem_word(e.addr)});
      if (s_rv && req_ready) fq.push_back(s_ra);
      if (exp_rv && req_ready) begin
        if (rand_lat) lat = $urandom_range(1, 4);
        due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
        mq.push_back('{exp_fetch, epoch, due});
        last_due = due;
        exp_fetch = exp_fetch + 4;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    force_rsp = 0;
  endtask

  task automatic test_reset();
    rst = 0;
    @(negedge clk);
    checks++;
    if (inst_valid !== 1'b0 || req_valid !== 1'b0 || pc_o !== 32'h0 || inst_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs iv=%b rv=%b pc=%h inst=%h exp 0 0 0 0", inst_valid, req_valid, pc_o, inst_o);
    end
    do_reset();
    cycle();
    checks++;
    if (s_rv !== 1'b1 || s_ra !== 32'h0) begin
      errors++;
      $display("FAIL first_request rv=%b addr=%h exp 1 00000000", s_rv, s_ra);
    end
  endtask

  task automatic test_stream();
    logic [31:0] pcs [8];
    logic ivs [8];
    do_reset();
    for (int k = 0; k < 8; k++) begin
      cycle();
      pcs[k] = s_pc;
      ivs[k] = s_iv;
    end
    checks++;
    if (ivs[0] !== 1'b0 || ivs[1] !== 1'b0) begin
      errors++;
      $display("FAIL stream_fill iv0=%b iv1=%b exp 0 0", ivs[0], ivs[1]);
    end
    for (int k = 2; k < 6; k++) begin
      checks++;
      if (ivs[k] !== 1'b1 || pcs[k] !== 32'(4 * (k - 2))) begin
        errors++;
        $display("FAIL stream_pc k=%0d iv=%b pc=%h exp 1 %h", k, ivs[k], pcs[k], 32'(4 * (k - 2)));
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    inst_ready = 0;
    repeat (10) cycle();
    checks++;
    if (fq.size() != 4 || s_rv !== 1'b0) begin
      errors++;
      $display("FAIL stall_credit fires=%0d rv=%b exp 4 0", fq.size(), s_rv);
    end
    inst_ready = 1;
    repeat (8) cycle();
    checks++;
    if (del_q.size() < 4 || del_q[0] !== 32'h0 || del_q[1] !== 32'h4 || del_q[2] !== 32'h8 || del_q[3] !== 32'hC) begin
      errors++;
      $display("FAIL stall_drain n=%0d first=%h exp 4 entries 0,4,8,c", del_q.size(), del_q.size() > 0 ? del_q[0] : 32'hx);
    end
    checks++;
    if (fq.size() < 5 || fq[4] !== 32'h10) begin
      errors++;
      $display("FAIL stall_resume n=%0d addr=%h exp 00000010", fq.size(), fq.size() > 4 ? fq[4] : 32'hx);
    end
  endtask

  task automatic test_hold();
    do_reset();
    repeat (2) cycle();
    hold = 1;
    repeat (5) cycle();
    checks++;
    if (fq.size() != 2 || del_q.size() != 2) begin
      errors++;
      $display("FAIL hold_freeze fires=%0d drained=%0d exp 2 2", fq.size(), del_q.size());
    end
    hold = 0;
    cycle();
    checks++;
    if (s_rv !== 1'b1 || s_ra !== 32'h8) begin
      errors++;
      $display("FAIL hold_resume rv=%b addr=%h exp 1 00000008", s_rv, s_ra);
    end
  endtask

  task automatic test_jump();
    do_reset();
    lat = 3;
    for (int k = 0; k < 10; k++) begin
      jump = (k == 2);
      hold = (k == 2);
      jump_addr = (k == 2) ? 32'h14294 : 32'h0;
      cycle();
      if (k == 3) begin
        checks++;
        if (s_rv !== 1'b1 || s_ra !== 32'h14294) begin
          errors++;
          $display("FAIL jump_target rv=%b addr=%h exp 1 00014294", s_rv, s_ra);
        end
      end
      if (k >= 3 && k <= 6) begin
        checks++;
        if (s_iv !== 1'b0) begin
          errors++;
          $display("FAIL jump_drop k=%0d iv=%b pc=%h exp iv 0", k, s_iv, s_pc);
        end
      end
      if (k == 7) begin
        checks++;
        if (s_iv !== 1'b1 || s_pc !== 32'h14294) begin
          errors++;
          $display("FAIL jump_first iv=%b pc=%h exp 1 00014294", s_iv, s_pc);
        end
      end
    end
  endtask

  task automatic test_spurious();
    do_reset();
    hold = 1;
    force_rsp = 1;
    cycle();
    cycle();
    checks++;
    if (s_iv !== 1'b0) begin
      errors++;
      $display("FAIL spurious_rsp iv=%b exp 0", s_iv);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    repeat (5) cycle();
    checks++;
    if (s_iv !== 1'b1) begin
      errors++;
      $display("FAIL areset_pre iv=%b exp 1", s_iv);
    end
    #3;
    rst = 0;
    #1;
    checks++;
    if (inst_valid !== 1'b0 || req_valid !== 1'b0 || pc_o !== 32'h0 || inst_o !== 32'h0) begin
      errors++;
      $display("FAIL areset_now iv=%b rv=%b pc=%h inst=%h exp 0 0 0 0", inst_valid, req_valid, pc_o, inst_o);
    end
    do_reset();
    cycle();
    checks++;
    if (s_rv !== 1'b1 || s_ra !== 32'h0) begin
      errors++;
      $display("FAIL areset_restart rv=%b addr=%h exp 1 00000000", s_rv, s_ra);
    end
  endtask

  task automatic test_random();
    do_reset();
    rand_lat = 1;
    for (int k = 0; k < 3000; k++) begin
      hold = $urandom_range(0, 9) == 0;
      req_ready = $urandom_range(0, 9) < 7;
      inst_ready = $urandom_range(0, 9) < 7;
      jump = $urandom_range(0, 24) == 0;
      jump_addr = $urandom & 32'hFFFF_FFFC;
      cycle();
    end
    jump = 0;
  endtask

  task automatic test_wrap();
    do_reset();
    @(negedge clk);
    checks++;
    if (w_rv !== 1'b1 || w_ra !== 8'hFC) begin
      errors++;
      $display("FAIL wrap_start rv=%b addr=%h exp 1 fc", w_rv, w_ra);
    end
    @(negedge clk);
    checks++;
    if (w_rv !== 1'b1 || w_ra !== 8'h00) begin
      errors++;
      $display("FAIL wrap_next rv=%b addr=%h exp 1 00", w_rv, w_ra);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_hold();
    test_jump();
    test_spurious();
    test_async_reset();
    test_random();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
